// File: rtl/parity_checker_moore.sv
// Serial running-parity checker, two-state Moore FSM.
// parity reflects the count of 1s sampled since the last reset edge.
module parity_checker_moore (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic parity
);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EVEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = EVEN;
        case (state)
            EVEN:    state_nxt = x ? ODD : EVEN;
            ODD:     state_nxt = x ? EVEN : ODD;
            default: state_nxt = EVEN;
        endcase
    end

    // Decoded from state only, so x never reaches parity between edges.
    always_comb begin
        parity = 1'b0;
        case (state)
            ODD:     parity = 1'b1;
            default: parity = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_parity_checker_moore.sv
// Directed and random checks for parity_checker_moore.
// Inputs change after the rising edge; outputs are sampled 1 ns after it.
module tb_parity_checker_moore;

    logic clk;
    logic reset;
    logic x;
    logic parity;

    int n_checks;
    int n_fail;

    parity_checker_moore dut (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .parity (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks, need summary", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        x     = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_edge: got %b want 0", parity);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (parity !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b want 0", i, parity);
            end
        end
    endtask

    task automatic test_toggle();
        logic [2:0] exp_seq;
        exp_seq = 3'b101;
        x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (parity !== exp_seq[2-i]) begin
                n_fail++;
                $display("FAIL toggle[%0d]: got %b want %b", i, parity, exp_seq[2-i]);
            end
        end
        x = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (parity !== 1'b1) begin
                n_fail++;
                $display("FAIL toggle_hold[%0d]: got %b want 1", i, parity);
            end
        end
    endtask

    task automatic test_midcycle();
        logic [2:0] exp_seq;
        exp_seq = 3'b010;
        #1;
        x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (parity !== exp_seq[2-i]) begin
                n_fail++;
                $display("FAIL midcycle[%0d]: got %b want %b", i, parity, exp_seq[2-i]);
            end
        end
        #1;
        x = 1'b0;
        #2;
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL midcycle_glitch_a: got %b want 0", parity);
        end
        #3;
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL midcycle_glitch_b: got %b want 0", parity);
        end
        tick();
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL midcycle_hold: got %b want 0", parity);
        end
    endtask

    task automatic test_reset_priority();
        x = 1'b1;
        tick();
        n_checks++;
        if (parity !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_setup: got %b want 1", parity);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_reset: got %b want 0", parity);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (parity !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_release: got %b want 1", parity);
        end
    endtask

    task automatic test_moore_isolation();
        logic [4:0] pat;
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            #1;
            x = pat[4-i];
            n_checks++;
            if (parity !== 1'b1) begin
                n_fail++;
                $display("FAIL iso_a[%0d]: got %b want 1", i, parity);
            end
        end
        tick();
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_edge_a: got %b want 0", parity);
        end
        pat = 5'b01010;
        for (int i = 0; i < 5; i++) begin
            #1;
            x = pat[4-i];
            n_checks++;
            if (parity !== 1'b0) begin
                n_fail++;
                $display("FAIL iso_b[%0d]: got %b want 0", i, parity);
            end
        end
        tick();
        n_checks++;
        if (parity !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_edge_b: got %b want 0", parity);
        end
    endtask

    task automatic test_random();
        logic model;
        reset = 1'b0;
        x     = 1'b1;
        tick();
        reset = 1'b1;
        model = 1'b0;
        n_checks++;
        if (parity !== model) begin
            n_fail++;
            $display("FAIL rand_reset: got %b want %b", parity, model);
        end
        for (int i = 0; i < 200; i++) begin
            x = 1'($urandom_range(0, 1));
            tick();
            model = model ^ x;
            n_checks++;
            if (parity !== model) begin
                n_fail++;
                $display("FAIL rand[%0d]: got %b want %b", i, parity, model);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        x        = 1'b0;
        test_reset();
        test_toggle();
        test_midcycle();
        test_reset_priority();
        test_moore_isolation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
